sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single base SRAM between two requesters: the CPU data path (via the device controller's RAM enable/read-enable/data signals) and a video line-fetch engine that needs read-only, latency-sensitive access. The block sits between the device controller and the SRAM pins in the top level. It sequences every SRAM cycle itself: chip/output/write enables, byte enables, address, tri-state write-drive enable, and a bus-turnaround gap. It replaces direct wiring of the SRAM controller to the device controller.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width.
- VID_BURST_MAX, 8, max consecutive video grants while CPU waits (used only with starvation guard).

Ports:
- clk  in  1  25 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_en_i  in  1  CPU access request, level, held until !cpu_busy_o.
- cpu_read_i  in  1  1 = read, 0 = write; stable while cpu_en_i.
- cpu_addr_i  in  ADDR_W  word address.
- cpu_be_i  in  4  byte select, active-high.
- cpu_wdata_i  in  32  write data.
- cpu_rdata_o  out  32  registered read data, held until next CPU read completes.
- cpu_busy_o  out  1  = cpu_en_i & !cpu_done (combinational).
- vid_req_i  in  1  video read request, level.
- vid_addr_i  in  ADDR_W  video word address.
- vid_ack_o  out  1  one-cycle pulse; vid_rdata_o valid in that cycle.
- vid_rdata_o  out  32  registered video read data.
- sram_addr_o  out  ADDR_W; sram_be_n_o  out  4; sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each.
- sram_drive_o  out  1  top level drives sram_wdata_o onto the data pins when 1.
- sram_wdata_o  out  32  write data to pins.
- sram_rdata_i  in  32  data from pins.

## Operation
- States: IDLE, RD, WR, WR_END.
- IDLE: all SRAM strobes high, be_n = 4'hF, drive = 0. Arbitration is evaluated here only. The winner's address, byte enables, data and owner are latched. Next state is RD for a read or WR for a write. With no request, stay in IDLE.
- Arbitration: video only → video. CPU only → CPU. Both → video wins (strict priority), unless the starvation guard forces the CPU.
- RD: ce_n = 0, oe_n = 0, be_n = ~latched be (video: 4'h0).
  - At the end of RD, sram_rdata_i is registered into the owner's rdata register.
  - Owner done asserted: vid_ack_o pulses, or cpu_done drops cpu_busy_o.
  - Next state is IDLE.
- WR (CPU only): ce_n = 0, we_n = 0, drive = 1, be_n = ~be. Next state is WR_END.
- WR_END: ce_n = 0, we_n = 1, drive = 1 (data hold). cpu_done asserted. Next state is IDLE.
- The forced return to IDLE is the turnaround cycle. Drive is never 1 while oe_n = 0.
- CPU writes with be = 0 still perform a full WR/WR_END sequence with all bytes masked.
- Requests deasserted mid-access do not abort; the access completes and done is signalled.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; ce_n/oe_n/we_n = 1; be_n = 4'hF; drive = 0; addr = 0; wdata = 0.
  - cpu_rdata_o = 0, vid_rdata_o = 0, vid_ack_o = 0; guard counter = 0.
- Reset mid-access: strobes release in the same instant. No done or ack is produced.
- Read: request seen in IDLE at cycle N → RD at N+1 → data and done/ack at N+2 (cycle after RD).
- Write: IDLE at N → WR at N+1 → WR_END at N+2, busy low during N+2 → IDLE at N+3.
- Throughput: one access per 3 cycles. Back-to-back reads are 3 cycles apart including turnaround.
- cpu_busy_o is high from cpu_en_i assertion until the done cycle. The CPU may change its request the cycle after busy falls.

## Configuration
- SRAM_ARB_STARVE_GUARD_EN defined:
  - A counter (width ⌈log2(VID_BURST_MAX+1)⌉) increments on each video grant made while cpu_en_i is high.
  - When the counter equals VID_BURST_MAX, the next IDLE grants the CPU even if video is requesting.
  - The counter clears on any CPU grant or when cpu_en_i is low at a grant.
- Not defined: strict video priority; no counter logic. The CPU may starve indefinitely.

## Test plan
- Reset, then CPU write addr 0x00010, be 4'hF, data 0xDEADBEEF, followed by a read of the same address.
  - Required: we_n low for exactly 1 cycle.
  - Required: cpu_rdata_o = 0xDEADBEEF; busy falls at N+2 for both accesses.
- CPU write be 4'b0101 of 0x11223344 over 0xAAAAAAAA.
  - Required: read returns 0xAA22AA44.
  - Required: sram_be_n_o = 4'b1010 during WR and WR_END.
- vid_req_i and cpu_en_i (read) asserted in the same cycle, with the guard off.
  - Required: video is granted first (ack at N+2); the CPU is granted in the next IDLE; data is returned 3 cycles later.
- Guard on, VID_BURST_MAX = 4, vid_req_i held and CPU read pending.
  - Required: exactly 4 vid_ack_o pulses, then the CPU completes, then video resumes.
- Assert rst_n low during WR.
  - Required: we_n, ce_n and drive return to inactive immediately; no done is produced; state is IDLE after release.
- Random mixed traffic (1000 accesses) checked against a reference memory model.
  - Required: drive and !oe_n never both asserted.
  - Required: no two SRAM accesses without an intervening IDLE cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares the single base SRAM between the CPU data path and the read-only
// video line-fetch engine, and sequences every SRAM cycle itself (strobes,
// byte enables, address, write-drive enable and a bus-turnaround gap).
//
// Optional feature macro: SRAM_ARB_STARVE_GUARD_EN
//   When defined, a counter limits consecutive video grants made while the
//   CPU is waiting to VID_BURST_MAX, after which the CPU is granted.
//   When undefined, video has strict priority and the CPU may starve.
//
// Ports:
//   clk, rst_n        25 MHz clock, asynchronous active-low reset
//   cpu_en_i          CPU request (level, held until !cpu_busy_o)
//   cpu_read_i        1 = read, 0 = write
//   cpu_addr_i        CPU word address
//   cpu_be_i          CPU byte select, active-high
//   cpu_wdata_i       CPU write data
//   cpu_rdata_o       registered CPU read data
//   cpu_busy_o        CPU access still in progress
//   vid_req_i         video read request (level)
//   vid_addr_i        video word address
//   vid_ack_o         one-cycle pulse, vid_rdata_o valid in that cycle
//   vid_rdata_o       registered video read data
//   sram_addr_o       SRAM word address
//   sram_be_n_o       SRAM byte enables, active-low
//   sram_ce_n_o       SRAM chip enable, active-low
//   sram_oe_n_o       SRAM output enable, active-low
//   sram_we_n_o       SRAM write enable, active-low
//   sram_drive_o      top level drives sram_wdata_o onto the pins when 1
//   sram_wdata_o      write data to pins
//   sram_rdata_i      data from pins

module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int VID_BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en_i,
    input  logic              cpu_read_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_be_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_busy_o,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,
    output logic [31:0]       vid_rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_be_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_drive_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD     = 2'd1;
    localparam logic [1:0] S_WR     = 2'd2;
    localparam logic [1:0] S_WR_END = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner_vid;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              cpu_rd_done_q;
    logic              cpu_done;
    logic              cpu_req;
    logic              turnaround;
    logic              can_grant;
    logic              grant_vid;
    logic              grant_cpu;

    // The IDLE cycle right after a read is the bus turnaround: the SRAM is
    // still releasing the data pins, so no new access may start there. The
    // done/ack pulses for reads fall in exactly that cycle.
    assign turnaround = vid_ack_o | cpu_rd_done_q;
    assign can_grant  = (state == S_IDLE) & ~turnaround;

    assign cpu_done   = cpu_rd_done_q | (state == S_WR_END);
    assign cpu_busy_o = cpu_en_i & ~cpu_done;
    assign cpu_req    = cpu_en_i & ~cpu_done;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(VID_BURST_MAX + 1);

    logic [CW-1:0] guard_cnt;
    logic          force_cpu;

    assign force_cpu = (guard_cnt == CW'(VID_BURST_MAX));
    assign grant_vid = can_grant & vid_req_i & ~(force_cpu & cpu_req);

    // Counts video grants made while the CPU is waiting; any CPU grant or a
    // video grant with the CPU idle starts the count over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_cnt <= '0;
        end else if (grant_cpu) begin
            guard_cnt <= '0;
        end else if (grant_vid) begin
            guard_cnt <= cpu_en_i ? guard_cnt + 1'b1 : '0;
        end
    end
`else
    assign grant_vid = can_grant & vid_req_i;
`endif

    assign grant_cpu = can_grant & cpu_req & ~grant_vid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_vid) begin
                    state_nxt = S_RD;
                end else if (grant_cpu) begin
                    state_nxt = cpu_read_i ? S_RD : S_WR;
                end
            end
            S_RD:     state_nxt = S_IDLE;
            S_WR:     state_nxt = S_WR_END;
            S_WR_END: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, winner latch and read-data capture. Read data is taken on the
    // edge that ends RD, so the owner's done/ack lines up with valid data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner_vid     <= 1'b0;
            be_q          <= 4'h0;
            addr_q        <= '0;
            wdata_q       <= 32'h0;
            cpu_rdata_o   <= 32'h0;
            vid_rdata_o   <= 32'h0;
            vid_ack_o     <= 1'b0;
            cpu_rd_done_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            vid_ack_o     <= (state == S_RD) & owner_vid;
            cpu_rd_done_q <= (state == S_RD) & ~owner_vid;
            if (state == S_RD) begin
                if (owner_vid) begin
                    vid_rdata_o <= sram_rdata_i;
                end else begin
                    cpu_rdata_o <= sram_rdata_i;
                end
            end
            if (grant_vid) begin
                owner_vid <= 1'b1;
                addr_q    <= vid_addr_i;
                be_q      <= 4'hF;
            end else if (grant_cpu) begin
                owner_vid <= 1'b0;
                addr_q    <= cpu_addr_i;
                be_q      <= cpu_be_i;
                wdata_q   <= cpu_wdata_i;
            end
        end
    end

    // Strobes are decoded straight from the state so that an asynchronous
    // reset releases them in the same instant.
    assign sram_ce_n_o  = (state == S_IDLE);
    assign sram_oe_n_o  = (state != S_RD);
    assign sram_we_n_o  = (state != S_WR);
    assign sram_drive_o = (state == S_WR) | (state == S_WR_END);
    assign sram_be_n_o  = (state == S_IDLE) ? 4'hF : ~be_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en;
    logic        cpu_read;
    logic [19:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        vid_req;
    logic [19:0] vid_addr;
    logic        vid_ack;
    logic [31:0] vid_rdata;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_drive;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram_mem [64];
    logic [31:0] ref_mem  [64];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(20), .VID_BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_en_i(cpu_en), .cpu_read_i(cpu_read), .cpu_addr_i(cpu_addr),
        .cpu_be_i(cpu_be), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .cpu_busy_o(cpu_busy),
        .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack),
        .vid_rdata_o(vid_rdata),
        .sram_addr_o(sram_addr), .sram_be_n_o(sram_be_n), .sram_ce_n_o(sram_ce_n),
        .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n), .sram_drive_o(sram_drive),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    // Simple asynchronous SRAM: byte writes land at the end of a we_n-low cycle.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_drive) begin
            for (int i = 0; i < 4; i++) begin
                if (!sram_be_n[i]) sram_mem[sram_addr[5:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 32'h0BAD0BAD;

    // Bus protocol watcher: no write drive during an output-enabled cycle,
    // and every access begins after an idle cycle (only WR->WR_END may be
    // two consecutive chip-enabled cycles).
    logic p_ce_n = 1'b1;
    logic p_we_n = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_oe_n) begin
                checks++;
                if (sram_drive !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL drive_during_oe drive=%b required 0 at %0t", sram_drive, $time);
                end
            end
            if (!sram_ce_n) begin
                checks++;
                if (!(p_ce_n || (!p_we_n && sram_we_n && sram_drive))) begin
                    errors++;
                    $display("[TB] FAIL idle_gap prev_ce_n=%b prev_we_n=%b required an idle cycle at %0t",
                             p_ce_n, p_we_n, $time);
                end
            end
        end
        p_ce_n = sram_ce_n;
        p_we_n = sram_we_n;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Runs one CPU access from a negedge; returns observations, updates the
    // reference memory when a write completes. lat = -1 on timeout.
    task automatic cpu_access(input logic rd, input logic [19:0] a, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rdata,
                              output int lat, output int we_cyc,
                              output logic [3:0] be_wr, output logic [3:0] be_end);
        cpu_en = 1'b1; cpu_read = rd; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
        lat = 0; we_cyc = 0; be_wr = 4'hF; be_end = 4'hF;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (!sram_we_n) begin we_cyc++; be_wr = sram_be_n; end
            if (!sram_ce_n && sram_we_n && sram_drive) be_end = sram_be_n;
            if (!cpu_busy) break;
        end
        if (cpu_busy) lat = -1;
        rdata = cpu_rdata;
        cpu_en = 1'b0;
        if (!rd && lat > 0) ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], wd, be);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cpu_en = 0; cpu_read = 0; cpu_addr = 0; cpu_be = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0;
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        repeat (2) @(negedge clk);
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin errors++;
            $display("[TB] FAIL reset_strobes got %b required 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
        checks++; if (sram_be_n !== 4'hF) begin errors++;
            $display("[TB] FAIL reset_be_n got %h required f", sram_be_n); end
        checks++; if (sram_drive !== 1'b0 || sram_addr !== 20'h0 || sram_wdata !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_bus drive=%b addr=%h wdata=%h required 0", sram_drive, sram_addr, sram_wdata); end
        checks++; if (cpu_rdata !== 32'h0 || vid_rdata !== 32'h0 || vid_ack !== 1'b0 || cpu_busy !== 1'b0) begin errors++;
            $display("[TB] FAIL reset_outputs cpu_rdata=%h vid_rdata=%h ack=%b busy=%b required 0",
                     cpu_rdata, vid_rdata, vid_ack, cpu_busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (sram_ce_n !== 1'b1) begin errors++;
            $display("[TB] FAIL idle_after_reset ce_n=%b required 1", sram_ce_n); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int lat, we; logic [3:0] bw, bend;
        @(negedge clk);
        cpu_access(1'b0, 20'h00010, 4'hF, 32'hDEADBEEF, rd, lat, we, bw, bend);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL write_latency got %0d required 2", lat); end
        checks++; if (we !== 1) begin errors++; $display("[TB] FAIL we_pulse_len got %0d required 1", we); end
        @(negedge clk);
        cpu_access(1'b1, 20'h00010, 4'hF, 32'h0, rd, lat, we, bw, bend);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL read_latency got %0d required 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data got %h required deadbeef", rd); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd; int lat, we; logic [3:0] bw, bend;
        @(negedge clk);
        cpu_access(1'b0, 20'h00020, 4'hF, 32'hAAAAAAAA, rd, lat, we, bw, bend);
        @(negedge clk);
        cpu_access(1'b0, 20'h00020, 4'b0101, 32'h11223344, rd, lat, we, bw, bend);
        checks++; if (bw !== 4'b1010) begin errors++; $display("[TB] FAIL be_n_wr got %b required 1010", bw); end
        checks++; if (bend !== 4'b1010) begin errors++; $display("[TB] FAIL be_n_wr_end got %b required 1010", bend); end
        @(negedge clk);
        cpu_access(1'b1, 20'h00020, 4'hF, 32'h0, rd, lat, we, bw, bend);
        checks++; if (rd !== 32'hAA22AA44) begin errors++; $display("[TB] FAIL byte_merge got %h required aa22aa44", rd); end
        // all bytes masked: full sequence, memory unchanged
        @(negedge clk);
        cpu_access(1'b0, 20'h00020, 4'h0, 32'h55555555, rd, lat, we, bw, bend);
        checks++; if (lat !== 2 || we !== 1) begin errors++;
            $display("[TB] FAIL masked_write lat=%0d we=%0d required 2 and 1", lat, we); end
        @(negedge clk);
        cpu_access(1'b1, 20'h00020, 4'hF, 32'h0, rd, lat, we, bw, bend);
        checks++; if (rd !== 32'hAA22AA44) begin errors++; $display("[TB] FAIL masked_data got %h required aa22aa44", rd); end
    endtask

    task automatic test_priority;
        int n, ack_at, cpu_at; logic [31:0] vd, cd;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 20'h5;
        cpu_en = 1'b1; cpu_read = 1'b1; cpu_addr = 20'h10; cpu_be = 4'hF;
        n = 0; ack_at = -1; cpu_at = -1; vd = 0; cd = 0;
        while (n < 40 && cpu_at < 0) begin
            @(negedge clk);
            n++;
            if (vid_ack && ack_at < 0) begin ack_at = n; vd = vid_rdata; vid_req = 1'b0; end
            if (!cpu_busy) begin cpu_at = n; cd = cpu_rdata; cpu_en = 1'b0; end
        end
        cpu_en = 1'b0; vid_req = 1'b0;
        checks++; if (ack_at !== 2) begin errors++; $display("[TB] FAIL vid_first_ack got %0d required 2", ack_at); end
        checks++; if (cpu_at !== 5) begin errors++; $display("[TB] FAIL cpu_after_vid got %0d required 5", cpu_at); end
        checks++; if (vd !== ref_mem[5]) begin errors++; $display("[TB] FAIL vid_data got %h required %h", vd, ref_mem[5]); end
        checks++; if (cd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL cpu_data got %h required deadbeef", cd); end
    endtask

`ifdef SRAM_ARB_STARVE_GUARD_EN
    task automatic test_starve_guard;
        int n, before, after; logic done_seen; logic [31:0] rd;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 20'h1;
        cpu_en = 1'b1; cpu_read = 1'b1; cpu_addr = 20'h20; cpu_be = 4'hF;
        n = 0; before = 0; after = 0; done_seen = 1'b0; rd = 0;
        while (n < 300 && !(done_seen && after > 0)) begin
            @(negedge clk);
            n++;
            if (vid_ack) begin
                checks++; if (vid_rdata !== ref_mem[vid_addr[5:0]]) begin errors++;
                    $display("[TB] FAIL guard_vid_data got %h required %h", vid_rdata, ref_mem[vid_addr[5:0]]); end
                if (done_seen) after++; else before++;
                vid_addr = {14'h0, 6'(vid_addr[5:0] + 6'd1)};
            end
            if (!done_seen && !cpu_busy) begin done_seen = 1'b1; rd = cpu_rdata; cpu_en = 1'b0; end
        end
        vid_req = 1'b0; cpu_en = 1'b0;
        @(negedge clk);
        checks++; if (before !== 4) begin errors++; $display("[TB] FAIL guard_burst got %0d acks required 4", before); end
        checks++; if (after !== 1) begin errors++; $display("[TB] FAIL guard_resume got %0d acks required 1", after); end
        checks++; if (rd !== ref_mem[32]) begin errors++; $display("[TB] FAIL guard_cpu_data got %h required %h", rd, ref_mem[32]); end
    endtask
`endif

    task automatic test_reset_mid_write;
        logic [31:0] rd; int lat, we; logic [3:0] bw, bend;
        @(negedge clk);
        cpu_en = 1'b1; cpu_read = 1'b0; cpu_addr = 20'h30; cpu_be = 4'hF; cpu_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("[TB] FAIL in_wr we_n=%b required 0", sram_we_n); end
        rst_n = 1'b0;
        #1;
        checks++; if ({sram_we_n, sram_ce_n, sram_drive} !== 3'b110) begin errors++;
            $display("[TB] FAIL reset_release we_n,ce_n,drive=%b required 110", {sram_we_n, sram_ce_n, sram_drive}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (cpu_busy !== 1'b1) begin errors++; $display("[TB] FAIL no_done_in_reset busy=%b required 1", cpu_busy); end
        end
        cpu_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (sram_ce_n !== 1'b1 || cpu_busy !== 1'b0) begin errors++;
            $display("[TB] FAIL idle_after_release ce_n=%b busy=%b required 1 0", sram_ce_n, cpu_busy); end
        cpu_access(1'b1, 20'h30, 4'hF, 32'h0, rd, lat, we, bw, bend);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL post_reset_latency got %0d required 2", lat); end
        checks++; if (rd !== ref_mem[48]) begin errors++; $display("[TB] FAIL aborted_write_data got %h required %h", rd, ref_mem[48]); end
    endtask

    task automatic test_random;
        int accesses, cyc; logic cpu_act;
        accesses = 0; cyc = 0; cpu_act = 1'b0;
        vid_req = 1'b0; cpu_en = 1'b0;
        while (accesses < 1000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (cpu_act && !cpu_busy) begin
                if (cpu_read) begin
                    checks++; if (cpu_rdata !== ref_mem[cpu_addr[5:0]]) begin errors++;
                        $display("[TB] FAIL rand_cpu_read addr=%h got %h required %h", cpu_addr, cpu_rdata, ref_mem[cpu_addr[5:0]]); end
                end else begin
                    ref_mem[cpu_addr[5:0]] = merge(ref_mem[cpu_addr[5:0]], cpu_wdata, cpu_be);
                end
                accesses++; cpu_act = 1'b0; cpu_en = 1'b0;
            end
            if (vid_ack) begin
                checks++; if (vid_rdata !== ref_mem[vid_addr[5:0]]) begin errors++;
                    $display("[TB] FAIL rand_vid_read addr=%h got %h required %h", vid_addr, vid_rdata, ref_mem[vid_addr[5:0]]); end
                accesses++;
                vid_addr = 20'($urandom_range(0, 63));
                vid_req = 1'($urandom_range(0, 1));
            end else if (!vid_req && $urandom_range(0, 2) == 0) begin
                vid_addr = 20'($urandom_range(0, 63));
                vid_req = 1'b1;
            end
            if (!cpu_act && $urandom_range(0, 1) == 1) begin
                cpu_read = 1'($urandom_range(0, 1));
                cpu_addr = 20'($urandom_range(0, 63));
                cpu_be = 4'($urandom);
                cpu_wdata = $urandom;
                cpu_en = 1'b1; cpu_act = 1'b1;
            end
        end
        vid_req = 1'b0; cpu_en = 1'b0;
        checks++; if (accesses < 1000) begin errors++;
            $display("[TB] FAIL rand_progress got %0d accesses required 1000", accesses); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_priority();
`ifdef SRAM_ARB_STARVE_GUARD_EN
        test_starve_guard();
`endif
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
